// File: rtl/stamp_hub_pkg.sv
// Shared defaults and flat-bus index helpers for the stamp/take merge hub.
package stamp_hub_pkg;

  localparam int DEF_NUM_UNITS = 5;
  localparam int DEF_NUM_SLOTS = 8;
  localparam int DEF_STAMP_W   = 3;
  localparam int DEF_TAKE_W    = 5;
  localparam int CNT_W         = 16;

  // Enable bit of unit u, slot s on the per-unit flattened enable buses.
  function automatic int en_bit(input int u, input int s, input int num_slots);
    return u * num_slots + s;
  endfunction

  // LSB of the value field of unit u, slot s on a flattened value bus.
  function automatic int val_off(input int u, input int s, input int num_slots,
                                 input int w);
    return (u * num_slots + s) * w;
  endfunction

endpackage

// File: rtl/stamp_hub_rr_grant.sv
// Greedy all-or-nothing grant over per-unit slot claims, visited from ptr_i upward.
module stamp_hub_rr_grant #(
  parameter int NUM_UNITS = 5,
  parameter int NUM_SLOTS = 8,
  parameter int PTR_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic [NUM_UNITS*2*NUM_SLOTS-1:0] claim_i,
  input  logic [PTR_W-1:0]                 ptr_i,
  output logic [NUM_UNITS-1:0]             grant_o,
  output logic                             any_denied_o,
  output logic [PTR_W-1:0]                 first_denied_o
);

  localparam int CW = 2 * NUM_SLOTS;

  logic [CW-1:0] claimed;
  logic [CW-1:0] cur_claim;
  int            idx;

  always_comb begin
    claimed        = '0;
    cur_claim      = '0;
    idx            = 0;
    grant_o        = '0;
    any_denied_o   = 1'b0;
    first_denied_o = ptr_i;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
      cur_claim = claim_i[idx*CW +: CW];
      // An idle unit has an empty claim and is therefore always granted.
      if ((cur_claim & claimed) == '0) begin
        grant_o[idx] = 1'b1;
        claimed      = claimed | cur_claim;
      end else if (!any_denied_o) begin
        any_denied_o   = 1'b1;
        first_denied_o = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stamp_hub.sv
// Stamp/take merge stage: rotating-priority conflict-free grant, registered toward the conveyor.
// Optional denied-cycle counter enabled by defining STAMP_HUB_CONFLICT_CNT_EN.
module stamp_hub
  import stamp_hub_pkg::*;
#(
  parameter int NUM_UNITS = DEF_NUM_UNITS,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int STAMP_W   = DEF_STAMP_W,
  parameter int TAKE_W    = DEF_TAKE_W
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [NUM_UNITS*NUM_SLOTS*STAMP_W-1:0] unit_stamp_flat,
  input  logic [NUM_UNITS*NUM_SLOTS-1:0]         unit_stamp_in,
  input  logic [NUM_UNITS*NUM_SLOTS*TAKE_W-1:0]  unit_take_flat,
  input  logic [NUM_UNITS*NUM_SLOTS-1:0]         unit_take_in,
  output logic [NUM_UNITS-1:0]                   unit_ready,
  output logic [NUM_SLOTS*STAMP_W-1:0]           conveyor_stamp_flat,
  output logic [NUM_SLOTS-1:0]                   conveyor_stamp_in,
  output logic [NUM_SLOTS*TAKE_W-1:0]            conveyor_take_flat,
  output logic [NUM_SLOTS-1:0]                   conveyor_take_in
`ifdef STAMP_HUB_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0]                       conflict_cnt
`endif
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS*2*NUM_SLOTS-1:0] claims;
  logic [NUM_UNITS-1:0]             grant;
  logic                             any_denied;
  logic [PTR_W-1:0]                 first_denied;

  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [NUM_SLOTS*STAMP_W-1:0] stamp_val_q, stamp_val_d;
  logic [NUM_SLOTS-1:0]         stamp_en_q, stamp_en_d;
  logic [NUM_SLOTS*TAKE_W-1:0]  take_val_q, take_val_d;
  logic [NUM_SLOTS-1:0]         take_en_q, take_en_d;

  // Claim layout per unit: stamp slots in the low half, take slots in the high half.
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_claim
    assign claims[u*2*NUM_SLOTS +: 2*NUM_SLOTS] =
      {unit_take_in[u*NUM_SLOTS +: NUM_SLOTS], unit_stamp_in[u*NUM_SLOTS +: NUM_SLOTS]};
  end

  stamp_hub_rr_grant #(
    .NUM_UNITS (NUM_UNITS),
    .NUM_SLOTS (NUM_SLOTS),
    .PTR_W     (PTR_W)
  ) u_rr_grant (
    .claim_i        (claims),
    .ptr_i          (ptr_q),
    .grant_o        (grant),
    .any_denied_o   (any_denied),
    .first_denied_o (first_denied)
  );

  always_comb begin
    if (!reset)     unit_ready = '0;
    else if (flush) unit_ready = '1;
    else            unit_ready = grant;
  end

  // Grants are conflict-free, so at most one unit hits any (slot, field).
  always_comb begin
    stamp_en_d  = '0;
    stamp_val_d = '0;
    take_en_d   = '0;
    take_val_d  = '0;
    if (!flush) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if (grant[u] && unit_stamp_in[en_bit(u, s, NUM_SLOTS)]) begin
            stamp_en_d[s] = 1'b1;
            stamp_val_d[s*STAMP_W +: STAMP_W] =
              unit_stamp_flat[val_off(u, s, NUM_SLOTS, STAMP_W) +: STAMP_W];
          end
          if (grant[u] && unit_take_in[en_bit(u, s, NUM_SLOTS)]) begin
            take_en_d[s] = 1'b1;
            take_val_d[s*TAKE_W +: TAKE_W] =
              unit_take_flat[val_off(u, s, NUM_SLOTS, TAKE_W) +: TAKE_W];
          end
        end
      end
    end
  end

  always_comb begin
    if (flush)           ptr_d = '0;
    else if (any_denied) ptr_d = first_denied;
    else                 ptr_d = ptr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      stamp_val_q <= '0;
      stamp_en_q  <= '0;
      take_val_q  <= '0;
      take_en_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      stamp_val_q <= stamp_val_d;
      stamp_en_q  <= stamp_en_d;
      take_val_q  <= take_val_d;
      take_en_q   <= take_en_d;
    end
  end

  assign conveyor_stamp_flat = stamp_val_q;
  assign conveyor_stamp_in   = stamp_en_q;
  assign conveyor_take_flat  = take_val_q;
  assign conveyor_take_in    = take_en_q;

`ifdef STAMP_HUB_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!flush && any_denied && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stamp_hub.sv
// Directed bench for stamp_hub: expected conveyor words queued per cycle, checked by a monitor.
module tb_stamp_hub;

  localparam int NU = 5;
  localparam int NS = 8;
  localparam int SW = 3;
  localparam int TW = 5;
  localparam int OW = NS + NS*SW + NS + NS*TW;

  logic               clk;
  logic               reset;
  logic               flush;
  logic [NU*NS*SW-1:0] unit_stamp_flat;
  logic [NU*NS-1:0]    unit_stamp_in;
  logic [NU*NS*TW-1:0] unit_take_flat;
  logic [NU*NS-1:0]    unit_take_in;
  logic [NU-1:0]       unit_ready;
  logic [NS*SW-1:0]    conveyor_stamp_flat;
  logic [NS-1:0]       conveyor_stamp_in;
  logic [NS*TW-1:0]    conveyor_take_flat;
  logic [NS-1:0]       conveyor_take_in;
`ifdef STAMP_HUB_CONFLICT_CNT_EN
  logic [15:0]         conflict_cnt;
`endif

  stamp_hub dut (
    .clk                 (clk),
    .reset               (reset),
    .flush               (flush),
    .unit_stamp_flat     (unit_stamp_flat),
    .unit_stamp_in       (unit_stamp_in),
    .unit_take_flat      (unit_take_flat),
    .unit_take_in        (unit_take_in),
    .unit_ready          (unit_ready),
    .conveyor_stamp_flat (conveyor_stamp_flat),
    .conveyor_stamp_in   (conveyor_stamp_in),
    .conveyor_take_flat  (conveyor_take_flat),
    .conveyor_take_in    (conveyor_take_in)
`ifdef STAMP_HUB_CONFLICT_CNT_EN
    ,
    .conflict_cnt        (conflict_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [OW-1:0] exp_q[$];
  int            pass_cnt  = 0;
  int            total_cnt = 0;
  bit            mon_en    = 1'b0;

  logic [NS-1:0]    e_si;
  logic [NS*SW-1:0] e_sf;
  logic [NS-1:0]    e_ti;
  logic [NS*TW-1:0] e_tf;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [OW-1:0] conv_word();
    return {conveyor_stamp_in, conveyor_stamp_flat, conveyor_take_in, conveyor_take_flat};
  endfunction

  function automatic logic [OW-1:0] e_pack();
    return {e_si, e_sf, e_ti, e_tf};
  endfunction

  // driver tasks
  task automatic clear_req();
    flush           = 1'b0;
    unit_stamp_flat = '0;
    unit_stamp_in   = '0;
    unit_take_flat  = '0;
    unit_take_in    = '0;
  endtask

  task automatic req_stamp(input int u, input int s, input logic [SW-1:0] v);
    unit_stamp_in[u*NS+s]            = 1'b1;
    unit_stamp_flat[(u*NS+s)*SW +: SW] = v;
  endtask

  task automatic req_take(input int u, input int s, input logic [TW-1:0] v);
    unit_take_in[u*NS+s]             = 1'b1;
    unit_take_flat[(u*NS+s)*TW +: TW] = v;
  endtask

  task automatic e_clear();
    e_si = '0; e_sf = '0; e_ti = '0; e_tf = '0;
  endtask

  task automatic e_stamp(input int s, input logic [SW-1:0] v);
    e_si[s] = 1'b1;
    e_sf[s*SW +: SW] = v;
  endtask

  task automatic e_take(input int s, input logic [TW-1:0] v);
    e_ti[s] = 1'b1;
    e_tf[s*TW +: TW] = v;
  endtask

  // Called at posedge+2 with inputs set; checks ready, queues next-cycle output.
  task automatic step(input string name, input logic [NU-1:0] exp_ready);
    #1;
    check(name, OW'(unit_ready), OW'(exp_ready));
    exp_q.push_back(e_pack());
    @(posedge clk);
    #2;
  endtask

  // monitor: every cycle the conveyor word is compared with the queued expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_q.size() > 0) check("conveyor", conv_word(), exp_q.pop_front());
        else if (conv_word() != '0) check("unexpected_output", conv_word(), '0);
      end
    end
  end

  initial begin
    reset = 1'b0;
    clear_req();
    e_clear();
    req_stamp(0, 2, 3'd5);
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", OW'(unit_ready), '0);
    check("reset_outputs", conv_word(), '0);
`ifdef STAMP_HUB_CONFLICT_CNT_EN
    check("reset_cnt", OW'(conflict_cnt), '0);
`endif
    #1;
    reset = 1'b1;
    clear_req();
    mon_en = 1'b1;

    e_clear();                                   step("idle_after_reset", 5'b11111);
    clear_req(); req_stamp(0, 2, 3'd5);
    e_clear(); e_stamp(2, 3'd5);                 step("single_ready", 5'b11111);
    clear_req(); e_clear();                      step("single_gone", 5'b11111);

    clear_req(); req_stamp(1, 4, 3'd1); req_stamp(3, 4, 3'd6);
    e_clear(); e_stamp(4, 3'd1);                 step("conflict_ready", 5'b10111);
    clear_req(); req_stamp(3, 4, 3'd6);
    e_clear(); e_stamp(4, 3'd6);                 step("hold_ready", 5'b11111);

    clear_req(); flush = 1'b1; req_stamp(1, 4, 3'd1); req_stamp(3, 4, 3'd6);
    e_clear();                                   step("flush_ready", 5'b11111);
    // ptr is back at 0, so unit 1 must win again
    clear_req(); req_stamp(1, 4, 3'd1); req_stamp(3, 4, 3'd6);
    e_clear(); e_stamp(4, 3'd1);                 step("post_flush_ready", 5'b10111);
    clear_req(); req_stamp(3, 4, 3'd6);
    e_clear(); e_stamp(4, 3'd6);                 step("post_flush_hold", 5'b11111);

    // ptr = 3: visit order 3,4,0,1 so unit 1 loses this time
    clear_req(); req_stamp(1, 4, 3'd2); req_stamp(3, 4, 3'd7);
    e_clear(); e_stamp(4, 3'd7);                 step("wrap_ready", 5'b11101);
    clear_req(); req_stamp(1, 4, 3'd2);
    e_clear(); e_stamp(4, 3'd2);                 step("wrap_hold", 5'b11111);

    clear_req(); req_stamp(0, 0, 3'd2); req_take(4, 7, 5'd9);
    e_clear(); e_stamp(0, 3'd2); e_take(7, 5'd9); step("disjoint_ready", 5'b11111);

    clear_req(); req_stamp(2, 3, 3'd4); req_take(2, 3, 5'd17);
    req_take(3, 5, 5'd31); req_stamp(4, 5, 3'd3);
    e_clear(); e_stamp(3, 3'd4); e_take(3, 5'd17); e_take(5, 5'd31); e_stamp(5, 3'd3);
    step("fields_ready", 5'b11111);

    // ptr = 1: unit 2 wins take slot 1; unit 0 is denied including its free stamp slot 0
    clear_req(); req_take(2, 1, 5'd10); req_stamp(2, 6, 3'd6);
    req_take(0, 1, 5'd20); req_stamp(0, 0, 3'd1);
    e_clear(); e_take(1, 5'd10); e_stamp(6, 3'd6); step("take_conflict_ready", 5'b11110);
    clear_req(); req_take(0, 1, 5'd20); req_stamp(0, 0, 3'd1);
    e_clear(); e_take(1, 5'd20); e_stamp(0, 3'd1); step("take_hold", 5'b11111);
    clear_req(); e_clear();                      step("idle_tail", 5'b11111);
    @(posedge clk);
    #2;
`ifdef STAMP_HUB_CONFLICT_CNT_EN
    check("cnt_main", OW'(conflict_cnt), OW'(16'd4));
`endif

    // mid-operation reset drops a registered write at once
    mon_en = 1'b0;
    clear_req(); req_stamp(2, 1, 3'd3);
    @(posedge clk);
    #1;
    check("pre_reset_write", OW'(conveyor_stamp_in), OW'(8'h02));
    reset = 1'b0;
    #1;
    check("mid_reset_outputs", conv_word(), '0);
    check("mid_reset_ready", OW'(unit_ready), '0);
`ifdef STAMP_HUB_CONFLICT_CNT_EN
    check("mid_reset_cnt", OW'(conflict_cnt), '0);
`endif
    clear_req();
    @(posedge clk);
    #2;
    reset  = 1'b1;
    mon_en = 1'b1;

    // three conflicting cycles then a flushed conflict
    clear_req(); req_stamp(1, 4, 3'd1); req_stamp(3, 4, 3'd6);
    e_clear(); e_stamp(4, 3'd1);                 step("cnt_c1", 5'b10111);
    clear_req(); req_stamp(1, 4, 3'd1); req_stamp(3, 4, 3'd6);
    e_clear(); e_stamp(4, 3'd6);                 step("cnt_c2", 5'b11101);
    clear_req(); req_stamp(1, 4, 3'd1); req_stamp(3, 4, 3'd6);
    e_clear(); e_stamp(4, 3'd1);                 step("cnt_c3", 5'b10111);
    clear_req(); flush = 1'b1; req_stamp(1, 4, 3'd1); req_stamp(3, 4, 3'd6);
    e_clear();                                   step("cnt_flush", 5'b11111);
    clear_req(); e_clear();                      step("cnt_idle", 5'b11111);
    @(posedge clk);
    #2;
`ifdef STAMP_HUB_CONFLICT_CNT_EN
    check("cnt_three", OW'(conflict_cnt), OW'(16'd3));
`endif
    check("queue_drained", OW'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
